// File: rtl/mac_tx_sched.sv
// Round-robin scheduler sharing one RMII MAC transmit interface between N_REQ packet sources.
// Optional feature: define MAC_TX_SCHED_IFG_EN to insert an IFG_CYCLES inter-frame gap (GAP
// state) after every completed frame before the next grant is issued.
module mac_tx_sched #(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned START_TIMEOUT = 15,
  parameter int unsigned IFG_CYCLES    = 48
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          i_req_doorbell,
  input  logic [N_REQ*1518*8-1:0]   i_req_pktbuf,
  input  logic [N_REQ*11-1:0]       i_req_maxaddr,
  output logic [N_REQ-1:0]          o_req_busy,
  output logic [N_REQ-1:0]          o_req_done,
  output logic [N_REQ-1:0]          o_req_err,
  output logic [1518*8-1:0]         o_tx_pktbuf,
  output logic [10:0]               o_tx_pktbuf_maxaddr,
  output logic                      o_tx_doorbell,
  input  logic                      i_tx_available
);

  localparam int unsigned BufW   = 1518 * 8;
  localparam int unsigned GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TW     = $clog2(START_TIMEOUT + 1);
  localparam logic [10:0] MaxIdx = 11'd1517;

  // Reject unsupported configurations at elaboration time.
  if (N_REQ < 2 || N_REQ > 8 || START_TIMEOUT < 1 || IFG_CYCLES < 1) begin : g_param_err
    $error("mac_tx_sched: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    StIdle,
    StRing,
    StWaitStart,
`ifdef MAC_TX_SCHED_IFG_EN
    StWaitDone,
    StGap
`else
    StWaitDone
`endif
  } state_e;

  state_e            r_state, w_state_next;
  logic [GW-1:0]     r_grant, w_grant_next;
  logic [GW-1:0]     r_last_grant, w_last_grant_next;
  logic [N_REQ-1:0]  r_pending, w_pending_next;
  logic [TW-1:0]     r_timer, w_timer_next, w_timer_inc;
  logic              r_tx_doorbell, w_tx_doorbell_next;
  logic [N_REQ-1:0]  r_req_done, w_req_done_next;
  logic [N_REQ-1:0]  r_req_err, w_req_err_next;
  logic              w_active;
  logic              w_arb_found;
  logic [GW-1:0]     w_arb_idx;
  logic [GW:0]       w_cand;
  logic [10:0]       w_maxaddr [N_REQ];
  logic [BufW-1:0]   w_pktbuf  [N_REQ];
`ifdef MAC_TX_SCHED_IFG_EN
  localparam int unsigned GapW = $clog2(IFG_CYCLES + 1);
  logic [GapW-1:0]   r_gap_cnt, w_gap_cnt_next, w_gap_inc;
`endif

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_maxaddr[g] = i_req_maxaddr[g*11 +: 11];
    assign w_pktbuf[g]  = i_req_pktbuf[g*BufW +: BufW];
  end

  // Granted requester's buffer goes straight to the TX interface.
  assign o_tx_pktbuf         = w_pktbuf[r_grant];
  assign o_tx_pktbuf_maxaddr = w_maxaddr[r_grant];
  assign o_tx_doorbell       = r_tx_doorbell;
  assign o_req_done          = r_req_done;
  assign o_req_err           = r_req_err;

  // A frame is in flight from the doorbell cycle until completion is seen.
  assign w_active   = (r_state == StRing) || (r_state == StWaitStart) || (r_state == StWaitDone);
  assign o_req_busy = r_pending | ({N_REQ{w_active}} & (N_REQ'(1) << r_grant));

  // Round-robin pick: first pending index after last_grant, wrapping to 0.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_cand      = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      w_cand = {1'b0, r_last_grant} + (GW+1)'(k);
      if (w_cand >= (GW+1)'(N_REQ)) w_cand = w_cand - (GW+1)'(N_REQ);
      if (!w_arb_found && r_pending[w_cand[GW-1:0]]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_cand[GW-1:0];
      end
    end
  end

  // Next-state, grant bookkeeping and registered output pulses.
  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_last_grant_next  = r_last_grant;
    // Doorbells from requesters already pending or in flight are dropped.
    w_pending_next     = r_pending | (i_req_doorbell & ~o_req_busy);
    w_timer_next       = r_timer;
    w_timer_inc        = r_timer + TW'(1);
    w_tx_doorbell_next = 1'b0;
    w_req_done_next    = '0;
    w_req_err_next     = '0;
`ifdef MAC_TX_SCHED_IFG_EN
    w_gap_cnt_next     = r_gap_cnt;
    w_gap_inc          = r_gap_cnt + GapW'(1);
`endif
    unique case (r_state)
      StIdle: begin
        if (w_arb_found && i_tx_available) begin
          w_grant_next              = w_arb_idx;
          w_pending_next[w_arb_idx] = 1'b0;
          if (w_maxaddr[w_arb_idx] > MaxIdx) begin
            w_req_err_next[w_arb_idx] = 1'b1;
            w_last_grant_next         = w_arb_idx;
          end else begin
            w_tx_doorbell_next = 1'b1;
            w_state_next       = StRing;
          end
        end
      end
      StRing: begin
        w_timer_next = '0;
        w_state_next = StWaitStart;
      end
      StWaitStart: begin
        if (!i_tx_available) begin
          w_state_next = StWaitDone;
        end else if (w_timer_inc == TW'(START_TIMEOUT)) begin
          w_req_err_next[r_grant] = 1'b1;
          w_last_grant_next       = r_grant;
          w_state_next            = StIdle;
        end else begin
          w_timer_next = w_timer_inc;
        end
      end
      StWaitDone: begin
        if (i_tx_available) begin
          w_req_done_next[r_grant] = 1'b1;
          w_last_grant_next        = r_grant;
`ifdef MAC_TX_SCHED_IFG_EN
          w_gap_cnt_next           = '0;
          w_state_next             = StGap;
`else
          w_state_next             = StIdle;
`endif
        end
      end
`ifdef MAC_TX_SCHED_IFG_EN
      StGap: begin
        if (w_gap_inc == GapW'(IFG_CYCLES)) w_state_next = StIdle;
        else w_gap_cnt_next = w_gap_inc;
      end
`endif
      default: w_state_next = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_grant       <= '0;
      r_last_grant  <= GW'(N_REQ - 1);
      r_pending     <= '0;
      r_timer       <= '0;
      r_tx_doorbell <= 1'b0;
      r_req_done    <= '0;
      r_req_err     <= '0;
`ifdef MAC_TX_SCHED_IFG_EN
      r_gap_cnt     <= '0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_last_grant  <= w_last_grant_next;
      r_pending     <= w_pending_next;
      r_timer       <= w_timer_next;
      r_tx_doorbell <= w_tx_doorbell_next;
      r_req_done    <= w_req_done_next;
      r_req_err     <= w_req_err_next;
`ifdef MAC_TX_SCHED_IFG_EN
      r_gap_cnt     <= w_gap_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_mac_tx_sched.sv
// Self-checking bench for mac_tx_sched: scoreboard of expected grant/completion events,
// with a small TX interface model driving tx_available.
module tb_mac_tx_sched;

  localparam int unsigned N     = 2;
  localparam int unsigned BufW  = 1518 * 8;
  localparam int unsigned TOUT  = 15;
  localparam int unsigned IFG   = 48;
  localparam int          KDone = 0;  // frame sent
  localparam int          KLen  = 1;  // rejected for bad length, no tx_doorbell
  localparam int          KTout = 2;  // tx_doorbell then start timeout

  typedef struct {
    int req;
    int kind;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_doorbell = '0;
  logic [N*BufW-1:0] req_pktbuf;
  logic [N*11-1:0]   req_maxaddr;
  logic [N-1:0]      req_busy, req_done, req_err;
  logic [BufW-1:0]   tx_pktbuf;
  logic [10:0]       tx_pktbuf_maxaddr;
  logic              tx_doorbell;
  logic              tx_available = 1'b1;

  logic [BufW-1:0]   buf_m [N];
  logic [10:0]       ma [N];
  exp_t              sb [$];
  int                n_chk = 0;
  int                n_fail = 0;
  int                cyc = 0;
  int                db_cyc = 0;
  int                done_cyc = -1;
  bit                gap_chk = 0;
  bit                stuck = 0;
  bit                model_busy = 0;
  logic              prev_db = 1'b0;

  assign req_pktbuf  = {buf_m[1], buf_m[0]};
  assign req_maxaddr = {ma[1], ma[0]};

  mac_tx_sched #(.N_REQ(N), .START_TIMEOUT(TOUT), .IFG_CYCLES(IFG)) u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_req_doorbell      (req_doorbell),
    .i_req_pktbuf        (req_pktbuf),
    .i_req_maxaddr       (req_maxaddr),
    .o_req_busy          (req_busy),
    .o_req_done          (req_done),
    .o_req_err           (req_err),
    .o_tx_pktbuf         (tx_pktbuf),
    .o_tx_pktbuf_maxaddr (tx_pktbuf_maxaddr),
    .o_tx_doorbell       (tx_doorbell),
    .i_tx_available      (tx_available)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // TX interface model: drop available 2 cycles after the doorbell, hold for 6 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_doorbell && !stuck) begin
        model_busy = 1;
        repeat (2) @(negedge clk);
        tx_available = 1'b0;
        repeat (6) @(negedge clk);
        tx_available = 1'b1;
        model_busy = 0;
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (tx_doorbell) begin
      chk_eq("tx_doorbell_width", 32'(prev_db), 32'd0);
      if (sb.size() == 0) begin
        chk_eq("unexpected_tx_doorbell", 32'd1, 32'd0);
      end else begin
        e = sb[0];
        chk_eq("tx_doorbell_for_rejected", 32'(e.kind == KLen), 32'd0);
        chk_eq("tx_maxaddr", 32'(tx_pktbuf_maxaddr), 32'(ma[e.req]));
        chk_eq("tx_pktbuf", 32'(tx_pktbuf === buf_m[e.req]), 32'd1);
      end
      if (gap_chk && done_cyc >= 0) begin
`ifdef MAC_TX_SCHED_IFG_EN
        chk_eq("ifg_spacing", 32'((cyc - done_cyc) > int'(IFG)), 32'd1);
`else
        chk_eq("b2b_spacing", 32'(cyc - done_cyc), 32'd1);
`endif
      end
      db_cyc = cyc;
    end
    prev_db = tx_doorbell;
    if ((req_done | req_err) != '0) begin
      if (sb.size() == 0) begin
        chk_eq("unexpected_done_err", 32'({req_done, req_err}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk_eq("evt_req", 32'(req_done | req_err), 32'(1 << e.req));
        chk_eq("evt_is_done", 32'(req_done != '0), 32'(e.kind == KDone));
        if (e.kind == KTout) chk_eq("timeout_latency", 32'(cyc - db_cyc), 32'(TOUT + 1));
        if (req_done != '0) done_cyc = cyc;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    done_cyc = -1;
  endtask

  task automatic ring(input logic [N-1:0] m);
    req_doorbell = m;
    @(posedge clk); #1 req_doorbell = '0;
  endtask

  task automatic push(input int r, input int k);
    exp_t e;
    e.req = r;
    e.kind = k;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk_eq("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_done(input int r, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (req_done[r]) break;
    end
    chk_eq("wait_done_timeout", 32'(i < budget), 32'd1);
  endtask

  initial begin
    int i;
    for (int k = 0; k < int'(N); k++) begin
      for (int b = 0; b < 1518; b++) buf_m[k][b*8 +: 8] = 8'($urandom);
    end
    ma[0] = 11'd59;
    ma[1] = 11'd100;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values and single-frame latency.
    do_reset();
    chk_eq("rst_busy", 32'(req_busy), 32'd0);
    chk_eq("rst_done_err", 32'({req_done, req_err}), 32'd0);
    chk_eq("rst_tx_doorbell", 32'(tx_doorbell), 32'd0);
    push(0, KDone);
    ring(2'b01);
    chk_eq("busy0_pending", 32'(req_busy), 32'b01);
    @(posedge clk); #1 chk_eq("db_latency2", 32'(tx_doorbell), 32'd1);
    @(posedge clk); #1 chk_eq("db_low_after", 32'(tx_doorbell), 32'd0);
    drain(200);
    chk_eq("busy0_clear", 32'(req_busy), 32'd0);

    // Same-cycle doorbells: req0 then req1, back to back.
    do_reset();
    push(0, KDone);
    push(1, KDone);
    gap_chk = 1;
    ring(2'b11);
    drain(400);
    gap_chk = 0;

    // Re-ringing on done alternates with the other requester.
    do_reset();
    push(0, KDone); push(1, KDone); push(0, KDone); push(1, KDone);
    ring(2'b11);
    wait_done(0, 200);
    ring(2'b01);
    wait_done(1, 200);
    ring(2'b10);
    drain(400);

    // Oversize frame rejected, then a normal request goes through.
    do_reset();
    ma[1] = 11'd1600;
    push(1, KLen);
    ring(2'b10);
    drain(50);
    chk_eq("busy_after_err", 32'(req_busy), 32'd0);
    push(0, KDone);
    ring(2'b01);
    drain(200);
    ma[1] = 11'd1517;

    // Start timeout, then next request served (maxaddr 1517 boundary accepted).
    do_reset();
    stuck = 1;
    push(0, KTout);
    ring(2'b01);
    drain(100);
    stuck = 0;
    push(1, KDone);
    ring(2'b10);
    drain(200);

    // Reset while waiting for completion.
    do_reset();
    push(0, KDone);
    ring(2'b01);
    for (i = 0; i < 50 && tx_available; i++) begin
      @(posedge clk); #1;
    end
    chk_eq("avail_fell", 32'(tx_available), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk_eq("midrst_busy", 32'(req_busy), 32'd0);
    chk_eq("midrst_done_err", 32'({req_done, req_err}), 32'd0);
    chk_eq("midrst_tx_doorbell", 32'(tx_doorbell), 32'd0);
    rst = 1'b0;
    for (i = 0; i < 50 && model_busy; i++) begin
      @(posedge clk); #1;
    end
    chk_eq("model_idle", 32'(model_busy), 32'd0);
    repeat (5) @(posedge clk);
    #1 push(1, KDone);
    ring(2'b10);
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
